// File: rtl/button_debounce_pkg.sv
// Shared definitions for the pushbutton front end: FSM states and default LFOSC timing.
// Used by button_debounce (optional long-press support via FOFE_BTN_LONG_PRESS_EN).
package button_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_t;

    // Defaults assume the ~10 kHz SB_LFOSC clock: 20 ms debounce, 1 s long press.
    localparam int LFOSC_HZ                = 10000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = LFOSC_HZ / 50;
    localparam int DEFAULT_LONG_CYCLES     = LFOSC_HZ;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_sync_debounce.sv
// Two-flop synchroniser, polarity normalisation and debounce counter for one button pin.
// rise/fall mark the clock edge on which a new debounced level is accepted.
module button_sync_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic rise,
    output logic fall
);

    localparam int              DB_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic            IDLE_PIN = BTN_ACTIVE_LOW;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            s;
    logic            accept;
    logic [DB_W-1:0] cnt_db;

    // Reset to the released pin level so a held button is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign s      = BTN_ACTIVE_LOW ? ~sync2 : sync2;
    assign accept = (s != btn_level) && (cnt_db == DB_LAST);
    assign rise   = accept & s;
    assign fall   = accept & ~s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= 1'b0;
            cnt_db    <= '0;
        end else if (s == btn_level) begin
            cnt_db <= '0;
        end else if (accept) begin
            btn_level <= s;
            cnt_db    <= '0;
        end else begin
            cnt_db <= cnt_db + DB_W'(1);
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Pushbutton front end: debounced level, press/release strobes and a wrapping press counter.
// Define FOFE_BTN_LONG_PRESS_EN to add the long-press detector (long_pulse, held_long).
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_raw,
    output logic               btn_level,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_pulse,
    output logic               held_long,
    output logic [COUNT_W-1:0] press_count
);

    logic       rise;
    logic       fall;
    btn_state_t state;

    button_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .rise     (rise),
        .fall     (fall)
    );

    // Strobes are registered on the same edge the debounced level changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            press_pulse   <= rise;
            release_pulse <= fall;
            if (rise && state == IDLE) begin
                press_count <= press_count + COUNT_W'(1);
            end
        end
    end

`ifdef FOFE_BTN_LONG_PRESS_EN
    localparam int                HOLD_W    = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] cnt_hold;

    // A release on the threshold edge wins, so that press never reports long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt_hold   <= '0;
            long_pulse <= 1'b0;
            held_long  <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (fall) begin
                state     <= IDLE;
                held_long <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state    <= PRESSED;
                            cnt_hold <= '0;
                        end
                    end
                    PRESSED: begin
                        if (cnt_hold == HOLD_LAST) begin
                            state      <= LONG;
                            long_pulse <= 1'b1;
                            held_long  <= 1'b1;
                        end else begin
                            cnt_hold <= cnt_hold + HOLD_W'(1);
                        end
                    end
                    LONG: begin
                        state <= LONG;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (fall) begin
            state <= IDLE;
        end else if (rise) begin
            state <= PRESSED;
        end
    end

    assign long_pulse = 1'b0;
    assign held_long  = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus randomized bouncing input.
// Expectations come from a sliding-window model of the debounce rules kept in the bench.
module tb_button_debounce;

    localparam int DB = 4;
    localparam int LC = 16;
    localparam int CW = 8;
`ifdef FOFE_BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          btn_raw = 1'b0;
    logic          btn_level;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;
    logic          held_long;
    logic [CW-1:0] press_count;

    int total = 0;
    int bad   = 0;
    int press_seen   = 0;
    int release_seen = 0;
    int long_seen    = 0;
    int base_p;
    int base_r;
    int base_l;

    logic          m_level   = 1'b0;
    logic          m_press   = 1'b0;
    logic          m_release = 1'b0;
    logic          m_long    = 1'b0;
    logic          m_held    = 1'b0;
    logic [CW-1:0] m_count   = '0;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC),
        .BTN_ACTIVE_LOW (1'b1),
        .COUNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .held_long    (held_long),
        .press_count  (press_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic raw, input int cycles);
        btn_raw = raw;
        tick(cycles);
    endtask

    task automatic doReset(input logic raw);
        btn_raw = raw;
        rst_n   = 1'b0;
        tick(2);
        rst_n   = 1'b1;
    endtask

    // Level flips once the last DB synchronised samples all disagree with it.
    initial begin
        logic pipe[$];
        logic win[$];
        logic s;
        bit   all_diff;
        int   age;
        age = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pipe      = '{1'b0, 1'b0};
                win.delete();
                m_level   = 1'b0;
                m_press   = 1'b0;
                m_release = 1'b0;
                m_long    = 1'b0;
                m_held    = 1'b0;
                m_count   = '0;
                age       = 0;
            end else begin
                s = pipe.pop_front();
                pipe.push_back(~btn_raw);
                win.push_back(s);
                if (win.size() > DB) void'(win.pop_front());
                all_diff = (win.size() == DB);
                foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
                m_press   = all_diff && !m_level;
                m_release = all_diff && m_level;
                if (all_diff) m_level = !m_level;
                if (m_press) begin
                    m_count = m_count + 1'b1;
                    age     = 0;
                end else if (m_level) begin
                    age++;
                end
                m_long = 1'b0;
                if (LONG_EN && m_level && age == LC && !m_held) begin
                    m_long = 1'b1;
                    m_held = 1'b1;
                end
                if (!m_level) m_held = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("btn_level", btn_level, m_level);
            checkOutput("press_pulse", press_pulse, m_press);
            checkOutput("release_pulse", release_pulse, m_release);
            checkOutput("long_pulse", long_pulse, m_long);
            checkOutput("held_long", held_long, m_held);
            checkOutput("press_count", press_count, m_count);
            if (press_pulse && release_pulse) checkOutput("pulse_exclusive", 1, 0);
            press_seen   += press_pulse;
            release_seen += release_pulse;
            long_seen    += long_pulse;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset with pin low, then release with the button up
        rst_n = 1'b0;
        btn_raw = 1'b0;
        tick(3);
        checkOutput("rst_level", btn_level, 0);
        checkOutput("rst_press", press_pulse, 0);
        checkOutput("rst_count", press_count, 0);
        checkOutput("rst_held", held_long, 0);
        rst_n = 1'b1;
        btn_raw = 1'b1;
        tick(10);
        checkOutput("idle_level", btn_level, 0);
        checkOutput("idle_count", press_count, 0);

        // Clean press and release
        applyStimulus(1'b0, 5);
        checkOutput("clean_early", press_pulse, 0);
        checkOutput("clean_early_lvl", btn_level, 0);
        tick(1);
        checkOutput("clean_press", press_pulse, 1);
        checkOutput("clean_level", btn_level, 1);
        checkOutput("clean_count", press_count, 1);
        tick(1);
        checkOutput("clean_once", press_pulse, 0);
        applyStimulus(1'b1, 6);
        checkOutput("clean_release", release_pulse, 1);
        checkOutput("clean_rel_lvl", btn_level, 0);
        tick(4);

        // Bounce on the falling edge
        doReset(1'b1);
        tick(4);
        base_p = press_seen;
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 5);
        checkOutput("bounce_early", press_pulse, 0);
        tick(1);
        checkOutput("bounce_press", press_pulse, 1);
        checkOutput("bounce_count", press_count, 1);
        tick(3);
        checkOutput("bounce_single", press_seen - base_p, 1);
        applyStimulus(1'b1, 10);

        // Long press then short press
        doReset(1'b1);
        tick(4);
        base_l = long_seen;
        applyStimulus(1'b0, 6);
        checkOutput("long_press", press_pulse, 1);
        tick(15);
        checkOutput("long_early", long_pulse, 0);
        tick(1);
        checkOutput("long_pulse", long_pulse, LONG_EN);
        checkOutput("long_held", held_long, LONG_EN);
        tick(1);
        checkOutput("long_once", long_pulse, 0);
        tick(7);
        applyStimulus(1'b1, 5);
        checkOutput("long_held_still", held_long, LONG_EN);
        tick(1);
        checkOutput("long_release", release_pulse, 1);
        checkOutput("long_held_clr", held_long, 0);
        tick(4);
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 20);
        checkOutput("long_count", long_seen - base_l, LONG_EN ? 1 : 0);

        // Wrap of press_count
        doReset(1'b1);
        tick(4);
        base_p = press_seen;
        base_r = release_seen;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 8);
            applyStimulus(1'b1, 8);
        end
        checkOutput("wrap_count", press_count, 0);
        checkOutput("wrap_presses", press_seen - base_p, 256);
        checkOutput("wrap_releases", release_seen - base_r, 256);

        // Reset mid-press with button held
        doReset(1'b1);
        tick(4);
        applyStimulus(1'b0, 24);
        checkOutput("mid_held", held_long, LONG_EN);
        rst_n = 1'b0;
        tick(2);
        checkOutput("mid_rst_level", btn_level, 0);
        checkOutput("mid_rst_held", held_long, 0);
        checkOutput("mid_rst_count", press_count, 0);
        rst_n = 1'b1;
        tick(5);
        checkOutput("mid_early", press_pulse, 0);
        tick(1);
        checkOutput("mid_press", press_pulse, 1);
        checkOutput("mid_count", press_count, 1);
        applyStimulus(1'b1, 10);

        // Randomized bouncing, long holds and occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0)
                applyStimulus(~btn_raw, $urandom_range(15, 40));
            else
                applyStimulus(~btn_raw, $urandom_range(1, 8));
        end
        applyStimulus(1'b1, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
